// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: state encoding, decode payload and opcode membership.
package fetch_unit_pkg;

    localparam int unsigned XLEN_W = 32;
    localparam int unsigned OPC_W  = 7;

    localparam logic [XLEN_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [OPC_W-1:0] {
        OPCODE_LOAD     = 7'h03,
        OPCODE_MISC_MEM = 7'h0F,
        OPCODE_OP_IMM   = 7'h13,
        OPCODE_AUIPC    = 7'h17,
        OPCODE_STORE    = 7'h23,
        OPCODE_OP       = 7'h33,
        OPCODE_LUI      = 7'h37,
        OPCODE_BRANCH   = 7'h63,
        OPCODE_JALR     = 7'h67,
        OPCODE_JAL      = 7'h6F,
        OPCODE_SYSTEM   = 7'h73
    } opcode_t;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_HOLD
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN_W-1:0] pc;
        logic [XLEN_W-1:0] instr;
    } if_id_t;

    function automatic logic is_legal_opcode(input logic [OPC_W-1:0] opc);
        case (opc)
            OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM, OPCODE_AUIPC,
            OPCODE_STORE, OPCODE_OP, OPCODE_LUI, OPCODE_BRANCH,
            OPCODE_JALR, OPCODE_JAL, OPCODE_SYSTEM: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, decode-side valid/ready hand-off,
// redirect from execute with kill of any in-flight response.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output opcode_t         if_opcode,
    output logic            if_illegal
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_kill;
    logic            r_if_valid;
    if_id_t          r_if;
    logic [XLEN-1:0] w_target;

    assign w_target = {redirect_pc[XLEN-1:2], 2'b00};

    // Fetch sequencer; redirect always wins over the normal progression.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FS_IDLE;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if       <= '0;
        end else begin
            case (r_state)
                FS_IDLE: begin
                    r_state <= FS_REQ;
                    if (redirect_valid) begin
                        r_pc <= w_target;
                    end
                end
                FS_REQ: begin
                    if (redirect_valid) begin
                        r_pc <= w_target;
                    end
                    // Accepted old address plus redirect: its response must be dropped.
                    if (imem_req_ready) begin
                        r_state <= FS_WAIT;
                        r_kill  <= redirect_valid;
                    end
                end
                FS_WAIT: begin
                    if (imem_resp_valid) begin
                        if (redirect_valid || r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= FS_REQ;
                            if (redirect_valid) begin
                                r_pc <= w_target;
                            end
                        end else begin
                            r_if       <= '{pc: r_pc, instr: imem_resp_data};
                            r_if_valid <= 1'b1;
                            r_pc       <= r_pc + PC_STEP;
                            r_state    <= FS_HOLD;
                        end
                    end else if (redirect_valid) begin
                        r_kill <= 1'b1;
                        r_pc   <= w_target;
                    end
                end
                FS_HOLD: begin
                    if (redirect_valid || if_ready) begin
                        r_if_valid <= 1'b0;
                        r_state    <= FS_REQ;
                        if (redirect_valid) begin
                            r_pc <= w_target;
                        end
                    end
                end
                default: begin
                    r_state <= FS_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid = (r_state == FS_REQ);
    assign imem_req_addr  = r_pc;

    assign if_valid   = r_if_valid;
    assign if_pc      = r_if.pc;
    assign if_instr   = r_if.instr;
    assign if_opcode  = opcode_t'(r_if.instr[OPC_W-1:0]);
    assign if_illegal = (r_if.instr[1:0] != 2'b11) || !is_legal_opcode(r_if.instr[OPC_W-1:0]);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against an
// instruction-stream reference model (next delivered PC, memory image).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;
    logic        if_illegal;

    logic        u1_req_valid;
    logic [31:0] u1_req_addr;
    logic        u1_resp_valid = 1'b0;
    logic [31:0] u1_resp_data = '0;
    logic        u1_if_valid;
    logic [31:0] u1_if_pc;
    logic [31:0] u1_if_instr;
    logic [6:0]  u1_if_opcode;
    logic        u1_if_illegal;

    int checks = 0;
    int errors = 0;

    // memory / responder state
    logic [31:0] mem_ovr [logic [31:0]];
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    bit          pend1;
    logic [31:0] pend1_addr;
    bit          ready_rand = 0;
    bit          ready_fix  = 1;
    bit          lat_rand   = 0;
    int          lat_fix    = 1;
    bit          spur_en    = 0;

    // reference model state and logs
    logic [31:0] exp_pc;
    bit          prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    bit          saw_dead;
    int          cyc;
    int          req_cnt;
    logic [31:0] req_log[$];
    logic [31:0] acc_log[$];
    int          acc_cyc[$];
    logic [31:0] req1_log[$];
    logic [31:0] acc1_log[$];

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode),
        .if_illegal     (if_illegal)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (u1_req_valid),
        .imem_req_ready (1'b1),
        .imem_req_addr  (u1_req_addr),
        .imem_resp_valid(u1_resp_valid),
        .imem_resp_data (u1_resp_data),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (u1_if_valid),
        .if_ready       (1'b1),
        .if_pc          (u1_if_pc),
        .if_instr       (u1_if_instr),
        .if_opcode      (u1_if_opcode),
        .if_illegal     (u1_if_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return 32'(a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic bit ref_illegal(input logic [31:0] instr);
        logic [6:0] legal [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                   7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        bit found = 0;
        foreach (legal[i]) if (legal[i] == instr[6:0]) found = 1;
        return (instr[1:0] != 2'b11) || !found;
    endfunction

    // One clock: observe this cycle's transfers, let the edge pass, drive the next cycle.
    task automatic step();
        if (rst_n) begin
            if (imem_req_valid) begin
                checks++;
                if (imem_req_addr[1:0] !== 2'b00) begin
                    errors++;
                    $display("FAIL req_align: addr %h, required low bits 00", imem_req_addr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                checks++;
                if (pend) begin
                    errors++;
                    $display("FAIL outstanding: new request %h while %h pending, required none pending", imem_req_addr, pend_addr);
                end
                pend      = 1;
                pend_addr = imem_req_addr;
                pend_cnt  = lat_rand ? int'($urandom_range(1, 3)) : lat_fix;
                req_log.push_back(imem_req_addr);
                req_cnt++;
            end
            if (prev_hold) begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_instr) begin
                    errors++;
                    $display("FAIL hold_stable: valid %b pc %h instr %h, required 1 %h %h", if_valid, if_pc, if_instr, prev_pc, prev_instr);
                end
            end
            if (if_valid) begin
                checks++;
                if (if_opcode !== if_instr[6:0] || if_illegal !== ref_illegal(if_instr)) begin
                    errors++;
                    $display("FAIL decode: opcode %h illegal %b, required %h %b", if_opcode, if_illegal, if_instr[6:0], ref_illegal(if_instr));
                end
                if (if_instr == 32'hDEAD_BEEF) saw_dead = 1;
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc & ~32'h3;
            end else if (if_valid && if_ready) begin
                checks++;
                if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL stream: pc %h instr %h, required %h %h", if_pc, if_instr, exp_pc, mem_word(exp_pc));
                end
                acc_log.push_back(if_pc);
                acc_cyc.push_back(cyc);
                exp_pc = exp_pc + 32'd4;
            end
            prev_hold  = if_valid && !if_ready && !redirect_valid;
            prev_pc    = if_pc;
            prev_instr = if_instr;
            if (u1_req_valid) begin
                pend1      = 1;
                pend1_addr = u1_req_addr;
                req1_log.push_back(u1_req_addr);
            end
            if (u1_if_valid) begin
                checks++;
                if (u1_if_instr !== mem_word(u1_if_pc) || u1_if_opcode !== u1_if_instr[6:0]
                    || u1_if_illegal !== ref_illegal(u1_if_instr)) begin
                    errors++;
                    $display("FAIL wrap_instr: pc %h instr %h, required instr %h", u1_if_pc, u1_if_instr, mem_word(u1_if_pc));
                end
                acc1_log.push_back(u1_if_pc);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom();
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pend_addr);
                pend            = 0;
            end else begin
                pend_cnt--;
            end
        end else if (spur_en && ($urandom_range(0, 7) == 0)) begin
            imem_resp_valid = 1'b1;
        end
        imem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
        u1_resp_valid  = pend1;
        u1_resp_data   = mem_word(pend1_addr);
        pend1          = 0;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        if_ready        = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        u1_resp_valid   = 1'b0;
        pend = 0; pend1 = 0; prev_hold = 0; req_cnt = 0;
        exp_pc = 32'h0;
        req_log.delete(); acc_log.delete(); acc_cyc.delete();
        req1_log.delete(); acc1_log.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input int max, input string name);
        int n = req_cnt;
        for (int i = 0; i < max && req_cnt == n; i++) step();
        if (req_cnt == n) begin
            checks++; errors++;
            $display("FAIL %s: no request within %0d cycles, required one", name, max);
        end
    endtask

    task automatic wait_valid(input int max, input string name);
        for (int i = 0; i < max && !if_valid; i++) step();
        if (!if_valid) begin
            checks++; errors++;
            $display("FAIL %s: if_valid 0 after %0d cycles, required 1", name, max);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: v %b pc %h instr %h rv %b ra %h, required 0 0 0 0 0", if_valid, if_pc, if_instr, imem_req_valid, imem_req_addr);
        end
        do_reset();
        ready_fix = 1; lat_fix = 1;
        repeat (3) step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            errors++;
            $display("FAIL first_fetch: valid %b pc %h, required 1 00000000", if_valid, if_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL midop_reset: valid %b rv %b ra %h, required 0 0 00000000", if_valid, imem_req_valid, imem_req_addr);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        ready_fix = 1; lat_fix = 1; if_ready = 1'b1;
        repeat (12) step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_log.size() <= i || req_log[i] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL seq_req%0d: addr %h, required %h", i, (req_log.size() > i) ? req_log[i] : 32'hx, 32'(4 * i));
            end
            checks++;
            if (acc_log.size() <= i || acc_log[i] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL seq_acc%0d: pc %h, required %h", i, (acc_log.size() > i) ? acc_log[i] : 32'hx, 32'(4 * i));
            end
        end
        for (int i = 0; i + 1 < 3; i++) begin
            checks++;
            if (acc_cyc.size() < 3 || acc_cyc[i + 1] - acc_cyc[i] != 3) begin
                errors++;
                $display("FAIL seq_rate%0d: spacing %0d, required 3", i, (acc_cyc.size() >= 3) ? acc_cyc[i + 1] - acc_cyc[i] : -1);
            end
        end
    endtask

    task automatic test_hold_stall();
        int n_req;
        int n_acc;
        mem_ovr[32'h300] = 32'h0000_0013;
        if_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        wait_valid(20, "hold_valid");
        checks++;
        if (if_pc !== 32'h300 || if_instr !== 32'h0000_0013) begin
            errors++;
            $display("FAIL hold_present: pc %h instr %h, required 00000300 00000013", if_pc, if_instr);
        end
        n_req = req_cnt;
        repeat (5) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_stall: valid %b req_valid %b, required 1 0", if_valid, imem_req_valid);
            end
        end
        checks++;
        if (req_cnt != n_req) begin
            errors++;
            $display("FAIL hold_noreq: %0d requests during stall, required 0", req_cnt - n_req);
        end
        if_ready = 1'b1;
        n_acc = acc_log.size();
        step();
        checks++;
        if (acc_log.size() != n_acc + 1 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept: accepted %0d valid %b, required 1 0", acc_log.size() - n_acc, if_valid);
        end
    endtask

    task automatic test_redirect_wait();
        ready_fix = 1; lat_fix = 2; if_ready = 1'b1;
        wait_req(20, "rw_req");
        mem_ovr[req_log[$]] = 32'hDEAD_BEEF;
        saw_dead = 0;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        wait_req(20, "rw_next");
        checks++;
        if (req_log[$] !== 32'h100) begin
            errors++;
            $display("FAIL rw_addr: addr %h, required 00000100", req_log[$]);
        end
        wait_valid(20, "rw_valid");
        checks++;
        if (if_pc !== 32'h100 || saw_dead) begin
            errors++;
            $display("FAIL rw_drop: pc %h dead_seen %b, required 00000100 0", if_pc, saw_dead);
        end
        step();
    endtask

    task automatic test_redirect_same_resp();
        ready_fix = 1; lat_fix = 1; if_ready = 1'b1;
        wait_req(20, "rs_req");
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        step();
        redirect_valid = 1'b0;
        wait_req(20, "rs_next");
        checks++;
        if (req_log[$] !== 32'h200) begin
            errors++;
            $display("FAIL rs_addr: addr %h, required 00000200", req_log[$]);
        end
        wait_valid(20, "rs_valid");
        checks++;
        if (if_pc !== 32'h200) begin
            errors++;
            $display("FAIL rs_pc: pc %h, required 00000200", if_pc);
        end
        step();
    endtask

    task automatic test_opcode_decode();
        logic [31:0] vals [3] = '{32'h0000_0033, 32'h0000_007F, 32'h0000_0010};
        logic [6:0]  opcs [3] = '{7'h33, 7'h7F, 7'h10};
        logic        ills [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) mem_ovr[32'h400 + 32'(4 * i)] = vals[i];
        if_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_valid(20, "opc_valid");
            checks++;
            if (if_instr !== vals[i] || if_opcode !== opcs[i] || if_illegal !== ills[i]) begin
                errors++;
                $display("FAIL opc%0d: instr %h opcode %h illegal %b, required %h %h %b", i, if_instr, if_opcode, if_illegal, vals[i], opcs[i], ills[i]);
            end
            if_ready = 1'b1;
            step();
            if_ready = 1'b0;
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        ready_fix = 1; lat_fix = 1; if_ready = 1'b1;
        repeat (12) step();
        checks++;
        if (req1_log.size() < 2 || req1_log[0] !== 32'hFFFF_FFFC || req1_log[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_req: n %0d first %h, required FFFFFFFC then 00000000", req1_log.size(), (req1_log.size() > 0) ? req1_log[0] : 32'hx);
        end
        checks++;
        if (acc1_log.size() < 2 || acc1_log[0] !== 32'hFFFF_FFFC || acc1_log[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: n %0d first %h, required FFFFFFFC then 00000000", acc1_log.size(), (acc1_log.size() > 0) ? acc1_log[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        int n_acc;
        ready_rand = 1; lat_rand = 1; spur_en = 1;
        n_acc = acc_log.size();
        repeat (1500) begin
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom();
            step();
        end
        redirect_valid = 1'b0;
        ready_rand = 0; lat_rand = 0; spur_en = 0;
        checks++;
        if (acc_log.size() - n_acc < 50) begin
            errors++;
            $display("FAIL rand_progress: %0d instructions accepted, required at least 50", acc_log.size() - n_acc);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_same_resp();
        test_opcode_decode();
        test_pc_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
